// File: rtl/mem_access_unit_pkg.sv
// Shared constants, FSM state type and nibble helpers for the nibble-RAM
// access controller.
package mem_access_unit_pkg;

    localparam int ADDR_W   = 12;
    localparam int NIB_W    = 4;
    localparam int MAX_NIBS = 3;
    localparam int DATA_W   = MAX_NIBS * NIB_W;

    // Largest legal encoded length (nibble count minus one).
    localparam logic [1:0] LEN_MAX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Select nibble idx out of a 12-bit data word.
    function automatic logic [NIB_W-1:0] nib_get(input logic [DATA_W-1:0] data,
                                                 input logic [1:0]        idx);
        logic [NIB_W-1:0] nib;
        case (idx)
            2'd0:    nib = data[3:0];
            2'd1:    nib = data[7:4];
            default: nib = data[11:8];
        endcase
        return nib;
    endfunction

    // Encoded length 3 is not a legal request; it behaves as 3 nibbles.
    function automatic logic [1:0] len_clamp(input logic [1:0] len);
        logic [1:0] res;
        if (len > LEN_MAX) begin
            res = LEN_MAX;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the core and the access controller.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [1:0]        req_len_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;

    // Controller side
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_len_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o
    );

    // Core side
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_len_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o
    );

endinterface

// File: rtl/mem_access_unit.sv
// Initiator-side controller for the 4096x4 nibble RAM: sequences 1-3
// consecutive nibble accesses per request and returns assembled load data.
// Every output is a flop loaded from the next-state values, so nothing on
// the request side reaches the RAM port combinationally.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    mem_access_unit_if.slave  req_if,
    output logic              ram_ren_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [NIB_W-1:0]  ram_din_o,
    input  logic [NIB_W-1:0]  ram_dout_i
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        len_q, len_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] build_q, build_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NIB_W-1:0]  din_q, din_d;

    // Next-state, request latching, load assembly and next output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        we_d    = we_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        build_d = build_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid_i) begin
                    we_d    = req_if.req_we_i;
                    base_d  = req_if.req_addr_i;
                    wdata_d = req_if.req_wdata_i;
                    len_d   = len_clamp(req_if.req_len_i);
                    idx_d   = 2'd0;
                    state_d = ST_ACCESS;
                    if (!req_if.req_we_i) begin
                        build_d = {DATA_W{1'b0}};
                    end else begin
                        build_d = build_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    build_d[32'(idx_q) * NIB_W +: NIB_W] = ram_dout_i;
                end else begin
                    build_d = build_q;
                end
                if (idx_q == len_q) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = build_d;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
        ren_d       = (state_d == ST_ACCESS) && !we_d;
        wen_d       = (state_d == ST_ACCESS) && we_d;
        if (state_d == ST_ACCESS) begin
            addr_d = base_d + ADDR_W'(idx_d);
        end else begin
            addr_d = {ADDR_W{1'b0}};
        end
        if (wen_d) begin
            din_d = nib_get(wdata_d, idx_d);
        end else begin
            din_d = {NIB_W{1'b0}};
        end
    end

    // State, request context and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            len_q       <= 2'd0;
            we_q        <= 1'b0;
            base_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            build_q     <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            din_q       <= {NIB_W{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            we_q        <= we_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            build_q     <= build_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign req_if.req_ready_o = ready_q;
    assign req_if.rsp_valid_o = rsp_valid_q;
    assign req_if.rsp_rdata_o = rdata_q;
    assign ram_ren_o          = ren_q;
    assign ram_wen_o          = wen_q;
    assign ram_addr_o         = addr_q;
    assign ram_din_o          = din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 4096x4 RAM responder.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        ram_ren;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [3:0]  ram_din;
    logic [3:0]  ram_dout;
    logic [3:0]  mem [0:4095];

    int errors = 0;
    int checks = 0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_if     (bus),
        .ram_ren_o  (ram_ren),
        .ram_wen_o  (ram_wen),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = ram_ren ? mem[ram_addr] : 4'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full request: drive at a falling edge, check every access cycle,
    // the DONE pulse and the return to IDLE.
    task automatic do_req(input logic we, input logic [11:0] addr, input logic [1:0] len,
                          input logic [11:0] wdata, input logic [11:0] exp_rdata);
        int          n;
        logic [11:0] a;
        logic [11:0] wd;
        n  = (len == 2'd3) ? 3 : int'(len) + 1;
        wd = wdata;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_len_i   = len;
        bus.req_wdata_i = wdata;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req_valid_i = 1'b0;
            a = addr + 12'(i);
            check("acc_ready", {31'd0, bus.req_ready_o}, 32'd0);
            check("acc_addr",  {20'd0, ram_addr}, {20'd0, a});
            check("acc_ren",   {31'd0, ram_ren}, {31'd0, ~we});
            check("acc_wen",   {31'd0, ram_wen}, {31'd0, we});
            if (we) check("acc_din", {28'd0, ram_din}, {28'd0, wd[i*4 +: 4]});
        end
        @(negedge clk);
        check("done_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
        check("done_ren",   {31'd0, ram_ren}, 32'd0);
        check("done_wen",   {31'd0, ram_wen}, 32'd0);
        check("done_addr",  {20'd0, ram_addr}, 32'd0);
        check("done_rdata", {20'd0, bus.rsp_rdata_o}, {20'd0, exp_rdata});
        @(negedge clk);
        check("idle_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("idle_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("idle_rdata", {20'd0, bus.rsp_rdata_o}, {20'd0, exp_rdata});
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 12'h000;
        bus.req_len_i   = 2'd0;
        bus.req_wdata_i = 12'h000;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("rst_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("rst_ren",   {31'd0, ram_ren}, 32'd0);
        check("rst_wen",   {31'd0, ram_wen}, 32'd0);
        check("rst_addr",  {20'd0, ram_addr}, 32'd0);
        check("rst_rdata", {20'd0, bus.rsp_rdata_o}, 32'd0);

        // Store 0xCBA at 0x100..0x102, then read back
        do_req(1'b1, 12'h100, 2'd2, 12'hCBA, 12'h000);
        check("mem_100", {28'd0, mem[12'h100]}, 32'hA);
        check("mem_101", {28'd0, mem[12'h101]}, 32'hB);
        check("mem_102", {28'd0, mem[12'h102]}, 32'hC);
        do_req(1'b0, 12'h100, 2'd2, 12'h000, 12'hCBA);

        // Single nibble load: upper nibbles cleared
        do_req(1'b0, 12'h101, 2'd0, 12'h000, 12'h00B);

        // Wrapping store, rdata held from last load
        do_req(1'b1, 12'hFFF, 2'd1, 12'h021, 12'h00B);
        check("mem_fff", {28'd0, mem[12'hFFF]}, 32'h1);
        check("mem_000", {28'd0, mem[12'h000]}, 32'h2);
        do_req(1'b0, 12'hFFF, 2'd1, 12'h000, 12'h021);

        // Length 3 behaves as 3 nibbles
        do_req(1'b0, 12'h100, 2'd3, 12'h000, 12'hCBA);

        // Valid held through a request: ignored while busy, accepted at IDLE
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 12'h102;
        bus.req_len_i   = 2'd0;
        @(negedge clk);
        check("b2b_acc1_ren", {31'd0, ram_ren}, 32'd1);
        check("b2b_acc1_rdy", {31'd0, bus.req_ready_o}, 32'd0);
        @(negedge clk);
        check("b2b_done1_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
        check("b2b_done1_ren",   {31'd0, ram_ren}, 32'd0);
        check("b2b_done1_rdata", {20'd0, bus.rsp_rdata_o}, 32'h00C);
        @(negedge clk);
        check("b2b_idle_rdy",   {31'd0, bus.req_ready_o}, 32'd1);
        check("b2b_idle_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("b2b_acc2_ren",  {31'd0, ram_ren}, 32'd1);
        check("b2b_acc2_addr", {20'd0, ram_addr}, 32'h102);
        @(negedge clk);
        check("b2b_done2_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
        @(negedge clk);
        check("b2b_end_valid", {31'd0, bus.rsp_valid_o}, 32'd0);

        // Abort: reset during the 2nd cycle of a 3-nibble store
        do_req(1'b1, 12'h200, 2'd2, 12'h555, 12'h00C);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 12'h200;
        bus.req_len_i   = 2'd2;
        bus.req_wdata_i = 12'h987;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("abort_acc0_wen", {31'd0, ram_wen}, 32'd1);
        @(negedge clk);
        check("abort_acc1_addr", {20'd0, ram_addr}, 32'h201);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("abort_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("abort_wen",   {31'd0, ram_wen}, 32'd0);
        check("abort_addr",  {20'd0, ram_addr}, 32'd0);
        check("abort_rdata", {20'd0, bus.rsp_rdata_o}, 32'd0);
        @(negedge clk);
        check("abort_valid2", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("abort_mem200", {28'd0, mem[12'h200]}, 32'h7);
        check("abort_mem201", {28'd0, mem[12'h201]}, 32'h8);
        check("abort_mem202", {28'd0, mem[12'h202]}, 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
